mul_unit: RTL and testbench

Iterative RV32M multiplier for the execute stage, downstream of the control unit. When the control unit decodes an R-type instruction with funct7 = 0000001 and funct3[2] = 0, it raises `start` with the operands and the low two funct3 bits. The unit computes MUL, MULH, MULHSU or MULHU with a radix-2 shift-add engine, then returns the 32-bit result with a one-cycle `done` pulse. `busy` stalls the pipeline while an operation is in flight.

---
 rtl/mul_unit.sv | 118 +++++++++++
 tb/tb_mul_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Iterative RV32M multiplier: radix-2 shift-add on operand magnitudes,
// followed by a single sign-fixup cycle. Covers MUL, MULH, MULHSU and MULHU.
module mul_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;   // multiplicand, pre-shifted by iteration
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand signedness and magnitudes for the request being presented.
  logic            s1_signed, s2_signed;
  logic            s1_neg, s2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic [2*XLEN-1:0] acc_fix;

  assign s1_signed = (op == 2'b01) || (op == 2'b10);
  assign s2_signed = (op == 2'b01);
  assign s1_neg    = s1_signed & rs1_val[XLEN-1];
  assign s2_neg    = s2_signed & rs2_val[XLEN-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag1      = s1_neg ? (~rs1_val + 1'b1) : rs1_val;
  assign mag2      = s2_neg ? (~rs2_val + 1'b1) : rs2_val;
  assign acc_fix   = neg_q ? (~acc_q + 1'b1) : acc_q;

  // Next-state, datapath and result selection.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          op_d     = op;
          neg_d    = s1_neg ^ s2_neg;
          mcand_d  = {{XLEN{1'b0}}, mag1};
          mplier_d = mag2;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_SIGN;
      end
      S_SIGN: begin
        acc_d    = acc_fix;
        result_d = (op_q == OP_MUL) ? acc_fix[XLEN-1:0] : acc_fix[2*XLEN-1:XLEN];
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_RUN) || (state_q == S_SIGN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: table vectors, random vectors against a wide-multiply
// model, and hand sequences for timing, reset, back-to-back and ignored starts.
module tb_mul_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct packed {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;
  vec_t tbl[10];

  mul_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] model(input logic [1:0] o,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic s1, s2;
    logic signed [2*XLEN+1:0] p;
    s1 = (o == 2'b01) || (o == 2'b10);
    s2 = (o == 2'b01);
    p = $signed({s1 & a[XLEN-1], a}) * $signed({s2 & b[XLEN-1], b});
    return (o == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse retires one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && busy === 1'b1 && done === 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL busy_done_overlap: busy=1 done=1 expected not both");
    end
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: result 0x%08h with no pending op", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // Issue one op and wait (bounded) for its done pulse.
  task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] e);
    bit seen = 0;
    op = o; rs1_val = a; rs2_val = b; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL timeout: done=0 expected done within 60 cycles");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Op with cycle-exact busy/done checks; optionally inject an ignored start in RUN.
  task automatic timed_op(input string name, input logic [1:0] o,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] e, input bit inject);
    int bad = 0;
    op = o; rs1_val = a; rs2_val = b; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (busy !== (k <= 33) || done !== (k == 34)) bad++;
      @(posedge clk); #1;
      if (inject && k == 4) begin
        start = 1'b1; op = 2'b11; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678;
      end
      if (inject && k == 5) start = 1'b0;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    tbl[0] = '{op: 2'b00, a: 32'h0000_0007, b: 32'hFFFF_FFFD, exp: 32'hFFFF_FFEB};
    tbl[1] = '{op: 2'b01, a: 32'h8000_0000, b: 32'h8000_0000, exp: 32'h4000_0000};
    tbl[2] = '{op: 2'b00, a: 32'h8000_0000, b: 32'h8000_0000, exp: 32'h0000_0000};
    tbl[3] = '{op: 2'b10, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
    tbl[4] = '{op: 2'b11, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFE};
    tbl[5] = '{op: 2'b01, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'h0000_0000};
    tbl[6] = '{op: 2'b01, a: 32'h7FFF_FFFF, b: 32'h8000_0000, exp: 32'hC000_0000};
    tbl[7] = '{op: 2'b10, a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp: 32'h8000_0000};
    tbl[8] = '{op: 2'b11, a: 32'h8000_0000, b: 32'h0000_0002, exp: 32'h0000_0001};
    tbl[9] = '{op: 2'b00, a: 32'h0000_0000, b: 32'h1234_5678, exp: 32'h0000_0000};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cycle-exact latency for the MUL example.
    timed_op("mul_timing", 2'b00, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);

    for (int i = 0; i < 10; i++) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] o; logic [XLEN-1:0] a, b;
      o = 2'($urandom_range(0, 3)); a = $urandom(); b = $urandom();
      run_op(o, a, b, model(o, a, b));
    end

    // Back-to-back with start held through DONE.
    begin
      bit seen = 0; int k = 0; int held_bad = 0;
      op = 2'b11; rs1_val = 32'h0001_0000; rs2_val = 32'h0001_0000; start = 1'b1;
      exp_q.push_back(32'h0000_0001);
      exp_q.push_back(32'h0000_0000);
      @(posedge clk); #1;
      op = 2'b00; rs1_val = 32'h0; rs2_val = 32'h1234_5678;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      @(posedge clk); #1 start = 1'b0;
      seen = 0;
      for (k = 1; k <= 60 && !seen; k++) begin
        @(negedge clk);
        if (done) seen = 1;
        else if (result !== 32'h0000_0001) held_bad++;
      end
      check("b2b_gap", 32'(k - 1), 32'd34);
      check("b2b_hold", 32'(held_bad), 32'd0);
      @(posedge clk); #1;
    end

    // Start during RUN is ignored.
    timed_op("ignored_start_timing", 2'b00, 32'd3, 32'd5, 32'd15, 1'b1);

    // Reset mid-RUN: in-flight op is lost.
    begin
      bit stray = 0;
      op = 2'b11; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("rst_run_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) stray = 1;
      end
      check("rst_no_done", 32'(stray), 32'd0);
      check("rst_result_after", result, 32'd0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
